uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//   Shares the single UART transmit byte stream (data_in/valid/ready of the uart block) among NUM_REQ requesters.
//   Examples of requesters: CPU MMIO path, debug monitor, boot loader.
//   Grants are round-robin and locked per packet: once granted, a requester owns the TX until it sends a byte flagged last.
//   A lock is also released if the owner stalls for TIMEOUT_CYCLES consecutive cycles.
//   Sits between the requesters and the uart data_in handshake.
// PARAMETERS
//   NUM_REQ        4      number of requesters, 2..8
//   TIMEOUT_CYCLES 65535  consecutive owner-idle cycles before forced release; 0 disables the timeout
// PORTS
//   clk            in   1          system clock
//   reset          in   1          asynchronous, active-high reset
//   req_data       in   NUM_REQ*8  requester i byte at [8*i+7:8*i]
//   req_valid      in   NUM_REQ    requester i has a byte
//   req_last       in   NUM_REQ    requester i byte is the final byte of its packet
//   req_ready      out  NUM_REQ    byte of requester i accepted this cycle
//   tx_data        out  8          to uart data_in
//   tx_valid       out  1          to uart data_in_valid
//   tx_ready       in   1          from uart data_in_ready
//   grant          out  NUM_REQ    one-hot current owner; all zeros when idle
//   busy           out  1          lock held (state LOCKED)
//   timeout_pulse  out  1          one-cycle pulse when a lock is force-released
// BEHAVIOUR
//   Reset values (async, immediate): state=IDLE, grant=0, busy=0, timeout_pulse=0, counter=0.
//     Also at reset: tx_valid=0, req_ready=0, and pointer last_owner=NUM_REQ-1, so requester 0 has first priority.
//   State IDLE:
//     Outputs: tx_valid=0, req_ready=0, tx_data=8'h00.
//     If any req_valid: pick the first requester set in req_valid, scanning last_owner+1, last_owner+2, ... modulo NUM_REQ.
//     On the next edge: grant<=onehot(pick), state<=LOCKED, counter<=0.
//     Arbitration latency is 1 cycle; no byte transfers in the arbitration cycle.
//   State LOCKED (owner k), combinational pass-through, no added latency:
//     tx_data=req_data[k], tx_valid=req_valid[k], req_ready[k]=tx_ready; req_ready of all others stays 0.
//     Transfer = req_valid[k] & tx_ready.
//     Transfer with req_last[k]=1: on the next edge state<=IDLE, grant<=0, last_owner<=k.
//       The other requesters are re-evaluated in IDLE on the following cycle.
//       A released owner cannot regain the lock back-to-back while any other requester is valid.
//     Transfer with req_last[k]=0: counter<=0, stay LOCKED.
//     req_valid[k]=0: counter<=counter+1.
//       When counter reaches TIMEOUT_CYCLES-1 and req_valid[k] is still 0: on the next edge state<=IDLE, grant<=0, last_owner<=k.
//       timeout_pulse=1 for exactly that following cycle.
//     req_valid[k]=1 with tx_ready=0 (UART back-pressure): counter is held. Back-pressure never counts as a stall.
//     If TIMEOUT_CYCLES=0: counter is unused and the lock is released only by last.
//   Counter is $clog2(TIMEOUT_CYCLES+1) bits, minimum 1 bit, and saturates without wrapping.
//   Changes on req_valid/req_data of non-owners have no effect while LOCKED.
//   NUM_REQ=1 is not supported and is rejected by elaboration check.
//   Reset asserted mid-packet: the lock drops immediately and tx_valid goes to 0 in the same cycle.
//     Any partially sent packet is abandoned; the requester must restart it.
//   busy == (state==LOCKED); grant is always one-hot or zero.
// TESTING
//   1. Single-byte packet:
//      Reset, then req_valid[2]=1, last[2]=1, data 8'h41, tx_ready=1.
//      Expect: grant=4'b0100 the cycle after request; tx_data=8'h41, tx_valid=1; req_ready[2]=1 for 1 cycle; grant=0 next cycle.
//   2. Round-robin:
//      All 4 requesters continuously valid with 1-byte packets.
//      Expect: grant order 0,1,2,3,0 with an idle cycle between grants.
//   3. Packet lock:
//      Req 1 sends 3 bytes (last on byte 3) while req 0 is valid throughout.
//      Expect: all 3 bytes of req 1 emitted contiguously before req 0 is granted; req_ready[0]=0 during the lock.
//   4. Back-pressure:
//      Owner valid, tx_ready=0 for 100 cycles with TIMEOUT_CYCLES=16.
//      Expect: no timeout; tx_data stable; transfer when tx_ready=1.
//   5. Timeout:
//      TIMEOUT_CYCLES=16, owner drops valid after byte 1 and before last.
//      Expect: grant=0 and timeout_pulse=1 exactly 16 cycles after the last transfer; next requester granted.
//   6. Reset mid-packet:
//      Assert reset during byte 2 of 4.
//      Expect: tx_valid=0, grant=0, busy=0 in the same cycle; after release, requester 0 has first priority.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked sharing of one UART TX byte stream among NUM_REQ requesters.
// An owner keeps the TX until it sends a byte flagged last, or until it stalls for TIMEOUT_CYCLES cycles.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 timeout_pulse
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("uart_tx_arbiter: NUM_REQ must be in 2..8");
  end
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state, state_n;
  logic [IW-1:0] owner, owner_n, last_owner, last_owner_n, pick, off;
  logic [CW-1:0] count, count_n;
  logic timeout_n;
  logic [NUM_REQ-1:0] rot;
  logic [7:0] bytes [NUM_REQ];
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_bytes
    assign bytes[i] = req_data[8*i +: 8];
  end
  // rotate so bit 0 is the requester just after last_owner; the lowest set bit wins
  always_comb begin
    rot = NUM_REQ'({req_valid, req_valid} >> (int'(last_owner) + 1));
    off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) off = rot[i] ? IW'(i) : off;
    pick = IW'((int'(last_owner) + 1 + int'(off)) % NUM_REQ);
  end
  always_comb begin
    state_n      = state;
    owner_n      = owner;
    last_owner_n = last_owner;
    count_n      = count;
    timeout_n    = 1'b0;
    tx_data      = 8'h00;
    tx_valid     = 1'b0;
    req_ready    = '0;
    if (state == IDLE) begin
      if (|req_valid) begin
        state_n = LOCKED;
        owner_n = pick;
        count_n = '0;
      end
    end else begin
      tx_data   = bytes[owner];
      tx_valid  = req_valid[owner];
      req_ready = NUM_REQ'(tx_ready) << owner;
      if (req_valid[owner] && tx_ready) begin
        count_n = '0;
        if (req_last[owner]) begin
          state_n      = IDLE;
          last_owner_n = owner;
        end
      end else if (!req_valid[owner] && TIMEOUT_CYCLES > 0) begin
        // back-pressure with valid held never reaches here, so it never counts as a stall
        if (count == LIMIT) begin
          state_n      = IDLE;
          last_owner_n = owner;
          timeout_n    = 1'b1;
        end else begin
          count_n = count == '1 ? count : count + 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      owner         <= '0;
      last_owner    <= IW'(NUM_REQ - 1);
      count         <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      state         <= state_n;
      owner         <= owner_n;
      last_owner    <= last_owner_n;
      count         <= count_n;
      timeout_pulse <= timeout_n;
    end
  end
  assign busy  = state == LOCKED;
  assign grant = busy ? NUM_REQ'(1) << owner : '0;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios plus randomized traffic checked against a behavioural model
// that tracks owner / last owner / stall run as plain integers.
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NR*8-1:0] req_data = '0;
  logic [NR-1:0] req_valid = '0;
  logic [NR-1:0] req_last = '0;
  logic [NR-1:0] req_ready, grant;
  logic [7:0] tx_data;
  logic tx_valid, busy, timeout_pulse;
  logic tx_ready = 1'b0;
  int checks = 0;
  int errors = 0;
  int m_own, m_last, m_stall;
  logic m_pulse;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .req_data(req_data), .req_valid(req_valid),
    .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .grant(grant), .busy(busy), .timeout_pulse(timeout_pulse)
  );

  function automatic logic vbit(logic [NR-1:0] v, int i);
    return ((v >> i) & 1) != 0;
  endfunction

  function automatic logic [7:0] byte_of(int i);
    return 8'(req_data >> (8 * i));
  endfunction

  function automatic void model_reset();
    m_own = -1;
    m_last = NR - 1;
    m_stall = 0;
    m_pulse = 1'b0;
  endfunction

  // owner -1 means idle; the pick scans forward from the previous owner
  function automatic void model_step();
    m_pulse = 1'b0;
    if (m_own < 0) begin
      for (int i = 1; i <= NR; i++)
        if (vbit(req_valid, (m_last + i) % NR)) begin
          m_own = (m_last + i) % NR;
          m_stall = 0;
          break;
        end
    end else if (vbit(req_valid, m_own)) begin
      if (tx_ready) begin
        m_stall = 0;
        if (vbit(req_last, m_own)) begin
          m_last = m_own;
          m_own = -1;
        end
      end
    end else begin
      m_stall++;
      if (m_stall == TO) begin
        m_pulse = 1'b1;
        m_last = m_own;
        m_own = -1;
      end
    end
  endfunction

  function automatic logic [NR-1:0] e_grant();
    return m_own < 0 ? '0 : NR'(1 << m_own);
  endfunction

  function automatic logic e_valid();
    return (m_own >= 0) && vbit(req_valid, m_own);
  endfunction

  function automatic logic [7:0] e_data();
    return m_own < 0 ? 8'h00 : byte_of(m_own);
  endfunction

  function automatic logic [NR-1:0] e_ready();
    return (m_own >= 0 && tx_ready) ? e_grant() : '0;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    req_last = '0;
    tx_ready = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = '1;
    req_last = '1;
    tx_ready = 1'b1;
    req_data = $urandom;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({grant, busy, tx_valid, req_ready, timeout_pulse} !== '0 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_hold: grant=%b busy=%b tx_valid=%b req_ready=%b pulse=%b tx_data=%h, expected all zero",
               grant, busy, tx_valid, req_ready, timeout_pulse, tx_data);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (grant !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: grant=%b busy=%b, expected 0000 0", grant, busy);
    end
    tick();
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0100;
    req_last = 4'b0100;
    req_data = 32'h0041_0000;
    tx_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0000 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_arb: grant=%b tx_valid=%b, expected 0000 0", grant, tx_valid);
    end
    tick();
    @(negedge clk);
    checks++;
    if (grant !== 4'b0100 || tx_data !== 8'h41 || tx_valid !== 1'b1 || req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL single_xfer: grant=%b tx_data=%h tx_valid=%b req_ready=%b, expected 0100 41 1 0100",
               grant, tx_data, tx_valid, req_ready);
    end
    tick();
    req_valid = '0;
    req_last = '0;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0000 || req_ready !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_release: grant=%b req_ready=%b busy=%b, expected 0000 0000 0", grant, req_ready, busy);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    do_reset();
    req_valid = '1;
    req_last = '1;
    tx_ready = 1'b1;
    req_data = 32'hD3C2_B1A0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      exp_g = (c % 2 == 1) ? 4'(1 << ((c / 2) % 4)) : 4'b0000;
      checks++;
      if (grant !== exp_g || (c % 2 == 1 && tx_data !== byte_of((c / 2) % 4))) begin
        errors++;
        $display("FAIL round_robin cycle %0d: grant=%b tx_data=%h, expected grant %b", c, grant, tx_data, exp_g);
      end
      tick();
    end
    req_valid = '0;
  endtask

  task automatic test_packet_lock();
    logic [7:0] b [3];
    do_reset();
    tx_ready = 1'b1;
    req_data = $urandom;
    req_valid = 4'b0001;
    req_last = 4'b0001;
    tick();
    tick();
    for (int i = 0; i < 3; i++) b[i] = 8'($urandom);
    req_valid = 4'b0011;
    req_last = 4'b0001;
    req_data[15:8] = b[0];
    @(negedge clk);
    checks++;
    if (grant !== 4'b0000) begin
      errors++;
      $display("FAIL lock_idle: grant=%b, expected 0000", grant);
    end
    tick();
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      checks++;
      if (grant !== 4'b0010 || tx_data !== b[j] || req_ready !== 4'b0010) begin
        errors++;
        $display("FAIL lock_byte %0d: grant=%b tx_data=%h req_ready=%b, expected 0010 %h 0010",
                 j, grant, tx_data, req_ready, b[j]);
      end
      tick();
      if (j < 2) begin
        req_data[15:8] = b[j+1];
        req_last[1] = (j == 1);
      end else begin
        req_valid[1] = 1'b0;
      end
    end
    @(negedge clk);
    checks++;
    if (grant !== 4'b0000) begin
      errors++;
      $display("FAIL lock_gap: grant=%b, expected 0000", grant);
    end
    tick();
    @(negedge clk);
    checks++;
    if (grant !== 4'b0001 || tx_data !== req_data[7:0]) begin
      errors++;
      $display("FAIL lock_next: grant=%b tx_data=%h, expected 0001 %h", grant, tx_data, req_data[7:0]);
    end
    tick();
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    logic [7:0] d;
    do_reset();
    req_valid = 4'b0001;
    req_last = 4'b0001;
    tx_ready = 1'b0;
    req_data = $urandom;
    d = req_data[7:0];
    tick();
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      checks++;
      if (grant !== 4'b0001 || tx_valid !== 1'b1 || tx_data !== d || req_ready !== 4'b0000 || timeout_pulse !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold %0d: grant=%b tx_valid=%b tx_data=%h req_ready=%b pulse=%b, expected 0001 1 %h 0000 0",
                 n, grant, tx_valid, tx_data, req_ready, timeout_pulse, d);
      end
      tick();
    end
    tx_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001 || tx_data !== d) begin
      errors++;
      $display("FAIL bp_xfer: req_ready=%b tx_data=%h, expected 0001 %h", req_ready, tx_data, d);
    end
    tick();
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0000 || timeout_pulse !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: grant=%b pulse=%b, expected 0000 0", grant, timeout_pulse);
    end
    tick();
  endtask

  task automatic test_timeout();
    logic [3:0] exp_g;
    do_reset();
    req_valid = 4'b0101;
    req_last = 4'b0000;
    tx_ready = 1'b1;
    req_data = $urandom;
    tick();
    @(negedge clk);
    checks++;
    if (grant !== 4'b0001 || req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL to_first: grant=%b req_ready=%b, expected 0001 0001", grant, req_ready);
    end
    tick();
    req_valid = 4'b0100;
    req_last = 4'b0100;
    for (int n = 1; n <= TO + 2; n++) begin
      @(negedge clk);
      exp_g = n <= TO ? 4'b0001 : (n == TO + 1 ? 4'b0000 : 4'b0100);
      checks++;
      if (grant !== exp_g || timeout_pulse !== (n == TO + 1)) begin
        errors++;
        $display("FAIL timeout cycle %0d: grant=%b pulse=%b, expected %b %b", n, grant, timeout_pulse, exp_g, n == TO + 1);
      end
      tick();
    end
    req_valid = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    tx_ready = 1'b1;
    req_data = $urandom;
    req_valid = 4'b0010;
    req_last = 4'b0010;
    tick();
    tick();
    req_valid = 4'b0100;
    req_last = 4'b0000;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (grant !== 4'b0100 || tx_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre: grant=%b tx_valid=%b, expected 0100 1", grant, tx_valid);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (tx_valid !== 1'b0 || grant !== 4'b0000 || busy !== 1'b0 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL rst_mid_drop: tx_valid=%b grant=%b busy=%b req_ready=%b, expected 0 0000 0 0000",
               tx_valid, grant, busy, req_ready);
    end
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    req_valid = '1;
    req_last = '1;
    @(negedge clk);
    checks++;
    if (grant !== 4'b0000) begin
      errors++;
      $display("FAIL rst_mid_idle: grant=%b, expected 0000", grant);
    end
    tick();
    @(negedge clk);
    checks++;
    if (grant !== 4'b0001) begin
      errors++;
      $display("FAIL rst_mid_prio: grant=%b, expected 0001", grant);
    end
    tick();
    req_valid = '0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      req_valid = (c % 100 < 20) ? '0 : NR'($urandom);
      req_last = NR'($urandom) & NR'($urandom);
      req_data = $urandom;
      tx_ready = $urandom_range(0, 3) != 0;
      @(negedge clk);
      checks++;
      if (grant !== e_grant() || busy !== (m_own >= 0) || tx_valid !== e_valid() || tx_data !== e_data() ||
          req_ready !== e_ready() || timeout_pulse !== m_pulse) begin
        errors++;
        $display("FAIL random cycle %0d: grant=%b busy=%b tx_valid=%b tx_data=%h req_ready=%b pulse=%b, expected %b %b %b %h %b %b",
                 c, grant, busy, tx_valid, tx_data, req_ready, timeout_pulse,
                 e_grant(), m_own >= 0, e_valid(), e_data(), e_ready(), m_pulse);
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_packet_lock();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
